// File: rtl/if_fetch_controller.sv
// rtl/if_fetch_controller.sv - MIPS IF stage: PC register, redirect/stall sequencing, IF/ID register
// Optional interrupt entry is compiled in with `define IRQ_EN.
module if_fetch_controller #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] IRQ_PC   = 32'h8000_0004
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_i,
   input  logic        id_jump_i,
   input  logic [31:0] id_jump_target_i,
   input  logic        ex_branch_i,
   input  logic [31:0] ex_branch_target_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_instr_i,
   output logic [31:0] ifid_instr_o,
   output logic [31:0] ifid_pc4_o,
   output logic        ifid_valid_o,
   output logic        flush_idex_o,
`ifdef IRQ_EN
   input  logic        irq_i,
   output logic [31:0] epc_o,
`endif
   output logic [31:0] pc_o
);

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] jump_target;
   logic [31:0] branch_target;
   logic        unused_bits;

   assign pc_plus4      = pc + 32'd4;
   assign jump_target   = {id_jump_target_i[31:2], 2'b00};
   assign branch_target = {ex_branch_target_i[31:2], 2'b00};
   assign unused_bits   = ^{IRQ_PC, id_jump_target_i[1:0], ex_branch_target_i[1:0]};

   assign imem_addr_o  = pc;
   assign pc_o         = pc;
   // The taken branch squashes the instruction currently sitting in ID.
   assign flush_idex_o = ex_branch_i;

`ifdef IRQ_EN
   logic irq_take;
   assign irq_take = irq_i && !pc[31];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc           <= RESET_PC;
         ifid_instr_o <= 32'h0;
         ifid_pc4_o   <= 32'h0;
         ifid_valid_o <= 1'b0;
`ifdef IRQ_EN
         epc_o        <= 32'h0;
`endif
      end else if (ex_branch_i) begin
         pc           <= branch_target;
         ifid_instr_o <= 32'h0;
         ifid_valid_o <= 1'b0;
      end else if (stall_i) begin
         pc           <= pc;
`ifdef IRQ_EN
      end else if (irq_take) begin
         // A jump losing to the interrupt becomes the return address.
         epc_o        <= id_jump_i ? id_jump_target_i : pc;
         pc           <= IRQ_PC;
         ifid_instr_o <= 32'h0;
         ifid_valid_o <= 1'b0;
`endif
      end else if (id_jump_i) begin
         pc           <= jump_target;
         ifid_instr_o <= 32'h0;
         ifid_valid_o <= 1'b0;
      end else begin
         pc           <= pc_plus4;
         ifid_instr_o <= imem_instr_i;
         ifid_pc4_o   <= pc_plus4;
         ifid_valid_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_if_fetch_controller.sv
// tb/tb_if_fetch_controller.sv - randomized bench for if_fetch_controller with an in-bench fetch model
module tb_if_fetch_controller;

   logic        clk;
   logic        reset;
   logic        stall_i;
   logic        id_jump_i;
   logic [31:0] id_jump_target_i;
   logic        ex_branch_i;
   logic [31:0] ex_branch_target_i;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_instr_i;
   logic [31:0] ifid_instr_o;
   logic [31:0] ifid_pc4_o;
   logic        ifid_valid_o;
   logic        flush_idex_o;
   logic [31:0] pc_o;

   logic [31:0] mem [256];
   int          n_cmp = 0;
   int          n_err = 0;
   logic        started = 1'b0;

   // reference state
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid;

   if_fetch_controller dut (
      .clk                (clk),
      .reset              (reset),
      .stall_i            (stall_i),
      .id_jump_i          (id_jump_i),
      .id_jump_target_i   (id_jump_target_i),
      .ex_branch_i        (ex_branch_i),
      .ex_branch_target_i (ex_branch_target_i),
      .imem_addr_o        (imem_addr_o),
      .imem_instr_i       (imem_instr_i),
      .ifid_instr_o       (ifid_instr_o),
      .ifid_pc4_o         (ifid_pc4_o),
      .ifid_valid_o       (ifid_valid_o),
      .flush_idex_o       (flush_idex_o),
      .pc_o               (pc_o)
   );

   // memory decodes only word-address bits, so addresses alias above word 255
   assign imem_instr_i = mem[imem_addr_o[9:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a taken branch beats everything, a stall freezes, a jump redirects, else fetch.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (ex_branch_i) begin
         m_pc = ex_branch_target_i & ~32'd3; m_instr = 32'h0; m_valid = 1'b0;
      end else if (!stall_i) begin
         if (id_jump_i) begin
            m_pc = id_jump_target_i & ~32'd3; m_instr = 32'h0; m_valid = 1'b0;
         end else begin
            m_instr = mem[(m_pc / 4) % 256];
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc4;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("pc", pc_o, m_pc);
         chk("imem_addr", imem_addr_o, m_pc);
         chk("ifid_instr", ifid_instr_o, m_instr);
         chk("ifid_pc4", ifid_pc4_o, m_pc4);
         chk("ifid_valid", {31'h0, ifid_valid_o}, {31'h0, m_valid});
         chk("flush_idex", {31'h0, flush_idex_o}, {31'h0, ex_branch_i});
      end
   end

   task automatic cyc(input logic s, input logic j, input logic [31:0] jt,
                      input logic b, input logic [31:0] bt);
      stall_i = s; id_jump_i = j; id_jump_target_i = jt;
      ex_branch_i = b; ex_branch_target_i = bt;
      @(posedge clk); #1;
      stall_i = 1'b0; id_jump_i = 1'b0; ex_branch_i = 1'b0;
   endtask

   initial begin
      logic [31:0] held;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[0] = 32'h2004_0000;
      mem[1] = 32'h2005_0020;
      mem[2] = 32'h2010_0000;
      reset = 1'b1; stall_i = 1'b0; id_jump_i = 1'b0; ex_branch_i = 1'b0;
      id_jump_target_i = 32'h0; ex_branch_target_i = 32'h0;
      @(posedge clk); #1;
      started = 1'b1;
      @(posedge clk); #1;
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_valid", {31'h0, ifid_valid_o}, 32'h0);
      chk("rst_instr", ifid_instr_o, 32'h0);
      chk("rst_flush", {31'h0, flush_idex_o}, 32'h0);
      reset = 1'b0;

      // sequential fetch
      cyc(0, 0, 0, 0, 0);
      chk("seq1_pc", pc_o, 32'h4);
      chk("seq1_instr", ifid_instr_o, 32'h2004_0000);
      chk("seq1_pc4", ifid_pc4_o, 32'h4);
      chk("seq1_valid", {31'h0, ifid_valid_o}, 32'h1);
      cyc(0, 0, 0, 0, 0);
      chk("seq2_pc", pc_o, 32'h8);
      chk("seq2_instr", ifid_instr_o, 32'h2005_0020);
      cyc(0, 0, 0, 0, 0);
      chk("seq3_pc", pc_o, 32'hC);
      cyc(0, 0, 0, 0, 0);
      chk("seq4_pc", pc_o, 32'h10);

      // stall three edges at 0x10, the jump alongside is ignored
      held = ifid_instr_o;
      for (int k = 0; k < 3; k++) begin
         cyc(1, 1, 32'h100, 0, 0);
         chk("stall_pc", pc_o, 32'h10);
         chk("stall_instr", ifid_instr_o, held);
      end
      cyc(0, 0, 0, 0, 0);
      chk("post_stall_pc", pc_o, 32'h14);
      chk("post_stall_instr", ifid_instr_o, mem[4]);
      chk("post_stall_pc4", ifid_pc4_o, 32'h14);
      repeat (4) cyc(0, 0, 0, 0, 0);
      chk("pre_branch_pc", pc_o, 32'h24);

      // branch beats stall and jump
      stall_i = 1'b1; id_jump_i = 1'b1; id_jump_target_i = 32'h40;
      ex_branch_i = 1'b1; ex_branch_target_i = 32'h0C;
      #1 chk("branch_flush", {31'h0, flush_idex_o}, 32'h1);
      @(posedge clk); #1;
      stall_i = 1'b0; id_jump_i = 1'b0; ex_branch_i = 1'b0;
      chk("branch_pc", pc_o, 32'h0C);
      chk("branch_instr", ifid_instr_o, 32'h0);
      chk("branch_valid", {31'h0, ifid_valid_o}, 32'h0);
      chk("branch_pc4", ifid_pc4_o, 32'h24);
      repeat (7) cyc(0, 0, 0, 0, 0);
      chk("pre_jump_pc", pc_o, 32'h28);

      // jump with misaligned target
      id_jump_i = 1'b1; id_jump_target_i = 32'h2D;
      #1 chk("jump_flush", {31'h0, flush_idex_o}, 32'h0);
      @(posedge clk); #1;
      id_jump_i = 1'b0;
      chk("jump_pc", pc_o, 32'h2C);
      chk("jump_instr", ifid_instr_o, 32'h0);
      chk("jump_valid", {31'h0, ifid_valid_o}, 32'h0);
      cyc(0, 0, 0, 0, 0);
      chk("after_jump_instr", ifid_instr_o, mem[11]);
      chk("after_jump_pc", pc_o, 32'h30);

      // wrap at the top of the address space
      cyc(0, 1, 32'hFFFF_FFFF, 0, 0);
      chk("wrap_top_pc", pc_o, 32'hFFFF_FFFC);
      cyc(0, 0, 0, 0, 0);
      chk("wrap_pc", pc_o, 32'h0);
      chk("wrap_pc4", ifid_pc4_o, 32'h0);
      chk("wrap_instr", ifid_instr_o, mem[255]);

      // asynchronous reset mid-cycle
      cyc(0, 0, 0, 0, 0);
      #2 reset = 1'b1;
      #1 chk("async_rst_pc", pc_o, 32'h0);
      chk("async_rst_valid", {31'h0, ifid_valid_o}, 32'h0);
      #3 reset = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_instr", ifid_instr_o, 32'h2004_0000);

      // randomized traffic, checked every cycle by the model
      for (int i = 0; i < 3000; i++) begin
         stall_i     = ($urandom % 4) == 0;
         id_jump_i   = ($urandom % 5) == 0;
         ex_branch_i = ($urandom % 7) == 0;
         id_jump_target_i   = (($urandom % 3) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
         ex_branch_target_i = (($urandom % 2) == 0) ? ($urandom % 1024) : $urandom;
         if (($urandom % 100) == 0) begin
            #2 reset = 1'b1;
            #3 reset = 1'b0;
         end
         @(posedge clk); #1;
      end
      stall_i = 1'b0; id_jump_i = 1'b0; ex_branch_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/if_fetch_controller.md
Name: if_fetch_controller

Overview:
Instruction-fetch stage controller for the 5-stage pipelined MIPS CPU. Owns the PC register and drives the word address into the combinational instruction memory. Captures the returned word into the IF/ID register. Sequences redirects from ID (j/jal/jr) and EX (taken branch) and honours hazard-unit stalls, inserting bubbles where required.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IRQ_PC, 32'h8000_0004, interrupt vector (used only with IRQ_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall_i  in  1  load-use hazard: hold PC and IF/ID
id_jump_i  in  1  jump resolved in ID this cycle
id_jump_target_i  in  32  jump target
ex_branch_i  in  1  branch resolved taken in EX this cycle
ex_branch_target_i  in  32  branch target
imem_addr_o  out  32  address to instruction memory (= pc)
imem_instr_i  in  32  instruction word returned combinationally
ifid_instr_o  out  32  IF/ID instruction register
ifid_pc4_o  out  32  IF/ID PC+4 register
ifid_valid_o  out  1  IF/ID holds a real instruction
flush_idex_o  out  1  bubble request to the ID/EX register
pc_o  out  32  current PC (debug/trace)

Behaviour:
- Reset (async, immediate): pc=RESET_PC; ifid_instr=0; ifid_pc4=0; ifid_valid=0. flush_idex_o is combinational and is 0 while inputs are idle.
- imem_addr_o = pc, combinational. Instruction is sampled in the same cycle: zero fetch latency; one cycle from PC to IF/ID.
- Target alignment: bits [1:0] of both targets are forced to 0 before loading into pc.
- PC+4 uses 32-bit modulo arithmetic: 32'hFFFF_FFFC wraps to 0.
- Priority on each rising edge, highest first:
  1. ex_branch_i: pc<=branch target. IF/ID<=bubble (instr=0, valid=0, pc4 unchanged). flush_idex_o=1. Overrides stall_i and id_jump_i.
  2. stall_i: pc and IF/ID hold. An id_jump_i in the same cycle is ignored; ID re-presents it after the stall.
  3. id_jump_i: pc<=jump target; IF/ID<=bubble. flush_idex_o=0.
  4. Otherwise: ifid_instr<=imem_instr_i; ifid_pc4<=pc+4; ifid_valid<=1; pc<=pc+4.
- flush_idex_o = ex_branch_i, combinational. The bubble squashes the instruction in ID.
- Bubble encoding: all-zero word (sll $0,$0,0). Downstream treats it as a nop.
- Memory decode aliases above word 255. The controller does not range-check; pc runs freely.
- Reset asserted mid-redirect or mid-stall discards all pending state. The first post-reset fetch is at RESET_PC.

Optional Feature:
IRQ_EN. When defined:
- Adds ports: irq_i (in, 1) and epc_o (out, 32, reset 0).
- On an edge with irq_i=1, pc[31]=0, stall_i=0 and ex_branch_i=0, the interrupt is taken:
  - epc_o<=pc (the unfetched instruction is replayed later).
  - pc<=IRQ_PC.
  - IF/ID<=bubble.
- Priority of the interrupt: below ex_branch_i, above id_jump_i. When the interrupt wins over a jump, epc_o<=id_jump_target_i, so the jump is not lost.
- With pc[31]=1 (kernel mode), irq_i is masked.

When undefined: the ports, register and logic are absent, and behaviour is exactly as in Behaviour.

Test Plan:
- Sequential fetch: release reset with the memory loaded with 32'h20040000, 32'h20050020, 32'h20100000, ... → pc steps 0,4,8,C on successive edges. After edge 1: ifid_instr=32'h20040000, ifid_pc4=4, valid=1. After edge 2: ifid_instr=32'h20050020.
- Jump: at pc=0x28, id_jump_i=1 with target 0x2D → pc=0x2C next edge, IF/ID bubble (instr 0, valid 0), flush_idex_o=0. The next edge fetches from 0x2C.
- Branch over stall: at pc=0x24, ex_branch_i=1 (target 0x0C), stall_i=1, id_jump_i=1 together → pc=0x0C, IF/ID bubble, flush_idex_o=1 during that cycle.
- Stall: stall_i high for 3 cycles at pc=0x10 → pc and ifid_instr constant for 3 edges. The 4th edge fetches from 0x10.
- Wrap and reset: force pc to 32'hFFFF_FFFC via jump target → next pc=0. Assert reset asynchronously mid-cycle → pc=0 and ifid_valid=0 immediately, without waiting for a clock edge.
- (IRQ_EN) irq_i=1 at pc=0x18, no stall → pc=0x80000004, epc_o=0x18, bubble. A further irq_i while pc[31]=1 → ignored.
